// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the buffered data memory.
package mem_pkg;
  localparam int ADDR_W_DEF   = 10;
  localparam int WB_DEPTH_DEF = 4;

  // The address is kept at the full 32-bit word width so the struct does not
  // depend on ADDR_W. Only the low ADDR_W bits are ever non-zero.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

  // Width of a counter that must hold the values 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/write_buf.sv
// Coalescing store FIFO with a parallel address lookup for load forwarding.
module write_buf
  import mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  localparam int CW      = cnt_w(WB_DEPTH),
  localparam int IW      = $clog2(WB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       wr_data,
  input  logic              push,
  input  logic              coal,
  input  logic              pop,
  output logic              hit,
  output logic [IW-1:0]     hit_idx,
  output logic [31:0]       hit_data,
  output wb_entry_t         head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  wb_entry_t             ent [WB_DEPTH];
  logic [WB_DEPTH-1:0]   vld;
  logic [WB_DEPTH-1:0]   hit_vec;
  logic [IW-1:0]         head_ptr, tail_ptr;

  // Wrap explicitly so WB_DEPTH need not be a power of two.
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    return (p == IW'(WB_DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  for (genvar i = 0; i < WB_DEPTH; i++) begin : g_cmp
    assign hit_vec[i] = vld[i] && (ent[i].addr == 32'(req_addr));
  end

  // Encode the (at most one) matching entry; coalescing keeps addresses unique.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++)
      if (hit_vec[i]) hit_idx = IW'(i);
  end

  assign hit      = |hit_vec;
  assign hit_data = ent[hit_idx].data;
  assign head     = ent[head_ptr];
  assign full     = (count == CW'(WB_DEPTH));
  assign empty    = (count == '0);

  // Valid bits, pointers and occupancy; push and pop never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld      <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (push) begin
      vld[tail_ptr] <= 1'b1;
      tail_ptr      <= inc(tail_ptr);
      count         <= count + CW'(1);
    end else if (pop) begin
      vld[head_ptr] <= 1'b0;
      head_ptr      <= inc(head_ptr);
      count         <= count - CW'(1);
    end
  end

  // Entry payload: new entry at the tail, or in-place update of the hit entry.
  always_ff @(posedge clk) begin
    if (push)      ent[tail_ptr]      <= '{addr: 32'(req_addr), data: wr_data};
    else if (coal) ent[hit_idx].data  <= wr_data;
  end
endmodule

// File: rtl/data_mem_wbuf.sv
// Word data memory with posted, coalescing stores drained in idle cycles.
module data_mem_wbuf
  import mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 data_adr,
  input  logic [31:0]                 data_wr,
  input  logic                        mem_read,
  input  logic                        mem_write,
  output logic [31:0]                 data_rd,
  output logic                        stall,
  output logic [cnt_w(WB_DEPTH)-1:0]  wb_count,
  output logic                        wb_empty
);
  localparam int IW = $clog2(WB_DEPTH);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] adr;
  logic              hit, full, empty, push, coal, pop;
  logic [IW-1:0]     hit_idx;
  logic [31:0]       hit_data;
  wb_entry_t         head;
  logic              unused_bits;

  assign adr = data_adr[ADDR_W-1:0];

  // A miss into a full buffer is the only store that cannot be taken.
  assign stall = mem_write & ~hit & full;
  assign push  = mem_write & ~hit & ~full;
  assign coal  = mem_write & hit;
  assign pop   = ~mem_read & ~mem_write & ~empty;

  assign wb_empty    = empty;
  assign unused_bits = ^{data_adr[31:ADDR_W], head.addr[31:ADDR_W], hit_idx};

  write_buf #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .req_addr (adr),
    .wr_data  (data_wr),
    .push     (push),
    .coal     (coal),
    .pop      (pop),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .hit_data (hit_data),
    .head     (head),
    .count    (wb_count),
    .full     (full),
    .empty    (empty)
  );

  // Zero-latency load; buffered data always wins over the (older) array copy.
  always_comb begin
    data_rd = '0;
    if (mem_read) data_rd = hit ? hit_data : mem[adr];
  end

  // Retire the oldest buffered store in an idle cycle. Array is not reset.
  always_ff @(posedge clk) begin
    if (pop) mem[head.addr[ADDR_W-1:0]] <= head.data;
  end
endmodule

// File: doc/data_mem_wbuf.md
# data_mem_wbuf

Word-addressed data memory that answers the pipeline's MEM-stage load/store requests. It sits on the other side of the datapath's data port: address, write data and read/write strobes in, read data out. Stores are posted into a small coalescing write buffer and retired to a single-port array in idle cycles. Loads always see the newest stored value through buffer forwarding. A stall output tells the hazard unit when a store cannot be accepted.

## Interface
- ADDR_W, 10: array index width; depth is 2**ADDR_W words of 32 bits.
- WB_DEPTH, 4: write-buffer entries, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- data_adr  in  32  word address; only bits [ADDR_W-1:0] are used, upper bits are ignored.
- data_wr  in  32  store data, from the datapath's data_out.
- mem_read  in  1  load request this cycle.
- mem_write  in  1  store request this cycle.
- data_rd  out  32  load data, to the datapath's data_in.
- stall  out  1  store not accepted this cycle; the hazard unit must freeze and re-present it.
- wb_count  out  $clog2(WB_DEPTH+1)  number of valid buffer entries.
- wb_empty  out  1  high when wb_count == 0.

## Operation
- Buffer: FIFO of entries, each {addr[ADDR_W-1:0], data[31:0]}, with head/tail pointers that wrap modulo WB_DEPTH. At most one valid entry exists per address.
- Hit: a valid entry whose addr equals data_adr[ADDR_W-1:0].
- Load (mem_read=1):
  - On a hit, data_rd = hit entry data.
  - Otherwise, data_rd = array[addr].
  - data_rd = 0 whenever mem_read = 0.
- Store (mem_write=1, stall=0):
  - On a hit, overwrite the hit entry's data in place (coalesce); count is unchanged.
  - Otherwise, push {addr, data_wr} at the tail; count +1.
- stall = mem_write & ~hit & (count == WB_DEPTH). It is combinational. A stalled store changes no state.
- Drain: in a cycle with mem_read=0 and mem_write=0 and a non-empty buffer, write the head entry to the array at the clock edge, pop it, and decrement count by 1. There is no drain in any cycle carrying a request.
- mem_read and mem_write together (the datapath never issues this):
  - data_rd returns the pre-store value.
  - The store follows the normal rules.
  - No drain occurs.
- Reset: clear all valid bits, pointers and count. wb_empty = 1 and wb_count = 0. Array contents are not reset.
- Reset asserted mid-operation discards all buffered stores; the array keeps only the entries already drained.

## Timing
- Load latency is 0 cycles: data_rd is combinational from data_adr, mem_read, the buffer and the array.
- A store is visible to a load in the next cycle, via forwarding.
- A store reaches the array after at least one idle cycle; worst case, after wb_count idle cycles.
- stall asserts in the same cycle as the offending store. The store is accepted at the first edge after which count < WB_DEPTH or a hit exists.
- wb_count and wb_empty are registered and update at the clock edge.
- Pointer wrap: after the tail reaches WB_DEPTH-1, the next push goes to entry 0. The same applies to the head.
- Simultaneous push and pop cannot occur, because a drain requires an idle cycle.

## Structure
- mem_pkg holds:
  - the default ADDR_W and WB_DEPTH;
  - the wb_entry_t struct {addr, data};
  - the function that computes count width.
- Sub-module write_buf holds:
  - the entry storage, valid bits and pointers;
  - a parallel address compare, with outputs hit, hit_idx and hit_data;
  - push, coalesce and pop ports, plus count.
- The top level holds the array and the request, drain and stall logic.

## Test plan
- Reset, then a load from address 5: data_rd = array[5] (preloaded 0xA5A5_0005); wb_empty = 1 and wb_count = 0.
- Store 0x1111_0001 to address 3, then immediately load address 3: data_rd = 0x1111_0001 and wb_count = 1. After one idle cycle, wb_count = 0 and array[3] = 0x1111_0001.
- Stores to address 7 of 0x1, then 0x2, back-to-back: wb_count stays 1, and a load from address 7 returns 0x2.
- Four stores to addresses 0–3, then a store to address 9 with no idle cycle: stall = 1 and wb_count = 4. After one idle cycle, the store to address 9 is accepted and array[0] holds the first store.
- Fill the buffer, then store to address 2 while it is full: stall = 0 because the store coalesces. After draining, array[2] holds the new value.
- Three stores buffered, then rst low for one cycle: wb_count = 0, and loads of those addresses return the old array values.
